// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit full-adder slice plus a carry register,
// sequenced over WIDTH/DIGIT cycles behind valid/ready handshakes on both sides.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT-1:0] da, db, dsum;
    logic [DIGIT:0]   dc;
    logic             last;

    // Digit select with constant slices keeps the mux free of wide index arithmetic.
    always_comb begin
        da = '0;
        db = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (cnt_q == CW'(i)) begin
                da = a_q[i*DIGIT +: DIGIT];
                db = b_q[i*DIGIT +: DIGIT];
            end
        end
    end

    // The single digit slice; dc[DIGIT-1] on the last digit is the carry into bit WIDTH-1.
    always_comb begin
        dc    = '0;
        dsum  = '0;
        dc[0] = carry_q;
        for (int j = 0; j < int'(DIGIT); j++) begin
            dsum[j]  = da[j] ^ db[j] ^ dc[j];
            dc[j+1]  = (da[j] & db[j]) | (dc[j] & (da[j] ^ db[j]));
        end
    end

    assign last      = (cnt_q == CW'(N - 1));
    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Subtract as a + ~b + ~cin so the same slice serves both operations.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    sub_d   = sub;
                    cnt_d   = '0;
                    s_d     = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int i = 0; i < int'(N); i++) begin
                    if (cnt_q == CW'(i)) begin
                        s_d[i*DIGIT +: DIGIT] = dsum;
                    end
                end
                carry_d = dc[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    cout_d  = dc[DIGIT] ^ sub_q;
                    ovf_d   = dc[DIGIT] ^ dc[DIGIT-1];
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: four WIDTH=8 instances with DIGIT = 1, 2, 4, 8
// sharing clock, reset and operand buses; each has its own handshake signals.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       in_valid    [4];
    logic       out_ready   [4];
    logic       in_ready_w  [4];
    logic       out_valid_w [4];
    logic [7:0] s_w         [4];
    logic       cout_w      [4];
    logic       ovf_w       [4];

    int checks;
    int errors;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_adder #(
            .WIDTH(8),
            .DIGIT(1 << g)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready_w[g]),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .sub      (sub),
            .out_valid(out_valid_w[g]),
            .out_ready(out_ready[g]),
            .s        (s_w[g]),
            .cout     (cout_w[g]),
            .ovf      (ovf_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int n_of(input int k);
        return 8 >> k;
    endfunction

    // Drives one operation on instance k and waits for its result; lat = -1 on timeout.
    task automatic do_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                         input logic ci, input logic su, output logic [7:0] so,
                         output logic co, output logic ov, output int lat, output time tacc);
        int t;
        so   = '0;
        co   = 1'b0;
        ov   = 1'b0;
        tacc = 0;
        t    = 0;
        while (!in_ready_w[k] && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready_w[k]) begin
            lat = -1;
            return;
        end
        a           = av;
        b           = bv;
        cin         = ci;
        sub         = su;
        in_valid[k] = 1'b1;
        @(posedge clk);
        tacc = $time;
        #1;
        in_valid[k] = 1'b0;
        // Scramble operands to show the latched copies are used.
        a   = ~av;
        b   = ~bv;
        cin = ~ci;
        sub = ~su;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid_w[k]) break;
        end
        if (!out_valid_w[k]) begin
            lat = -1;
            return;
        end
        so = s_w[k];
        co = cout_w[k];
        ov = ovf_w[k];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (in_ready_w[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_in_ready[%0d]: got %b want 0", k, in_ready_w[k]);
            end
            checks++;
            if (out_valid_w[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid[%0d]: got %b want 0", k, out_valid_w[k]);
            end
            checks++;
            if (s_w[k] !== 8'h00 || cout_w[k] !== 1'b0 || ovf_w[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got s=%h cout=%b ovf=%b want 00 0 0",
                         k, s_w[k], cout_w[k], ovf_w[k]);
            end
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (in_ready_w[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release_in_ready[%0d]: got %b want 1", k, in_ready_w[k]);
            end
        end
    endtask

    task automatic test_add_d1();
        logic [7:0] va [3] = '{8'hFF, 8'h7F, 8'h0F};
        logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h0F};
        logic       vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] es [3] = '{8'h00, 8'h80, 8'h1F};
        logic       eco[3] = '{1'b1, 1'b0, 1'b0};
        logic       eov[3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] so;
        logic       co, ov;
        int         lat;
        time        tacc;
        out_ready[0] = 1'b1;
        for (int v = 0; v < 3; v++) begin
            do_op(0, va[v], vb[v], vc[v], 1'b0, so, co, ov, lat, tacc);
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL add_d1_latency[%0d]: got %0d want 8", v, lat);
            end
            checks++;
            if (so !== es[v] || co !== eco[v] || ov !== eov[v]) begin
                errors++;
                $display("FAIL add_d1_result[%0d]: got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
                         v, so, co, ov, es[v], eco[v], eov[v]);
            end
        end
    endtask

    task automatic test_sub_d4();
        logic [7:0] va [2] = '{8'h05, 8'h80};
        logic [7:0] vb [2] = '{8'h07, 8'h01};
        logic [7:0] es [2] = '{8'hFE, 8'h7F};
        logic       eco[2] = '{1'b1, 1'b0};
        logic       eov[2] = '{1'b0, 1'b1};
        logic [7:0] so;
        logic       co, ov;
        int         lat;
        time        tacc;
        out_ready[2] = 1'b1;
        for (int v = 0; v < 2; v++) begin
            do_op(2, va[v], vb[v], 1'b0, 1'b1, so, co, ov, lat, tacc);
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL sub_d4_latency[%0d]: got %0d want 2", v, lat);
            end
            checks++;
            if (so !== es[v] || co !== eco[v] || ov !== eov[v]) begin
                errors++;
                $display("FAIL sub_d4_result[%0d]: got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
                         v, so, co, ov, es[v], eco[v], eov[v]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] so;
        logic       co, ov;
        int         lat;
        time        tacc;
        out_ready[0] = 1'b0;
        do_op(0, 8'h12, 8'h34, 1'b0, 1'b0, so, co, ov, lat, tacc);
        checks++;
        if (lat !== 8 || so !== 8'h46) begin
            errors++;
            $display("FAIL bp_first_result: got lat=%0d s=%h want lat=8 s=46", lat, so);
        end
        a           = 8'hAA;
        b           = 8'h55;
        cin         = 1'b1;
        sub         = 1'b0;
        in_valid[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid_w[0] !== 1'b1 || in_ready_w[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_handshake[%0d]: got out_valid=%b in_ready=%b want 1 0",
                         c, out_valid_w[0], in_ready_w[0]);
            end
            checks++;
            if (s_w[0] !== 8'h46 || cout_w[0] !== 1'b0 || ovf_w[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_result[%0d]: got s=%h cout=%b ovf=%b want 46 0 0",
                         c, s_w[0], cout_w[0], ovf_w[0]);
            end
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid_w[0] !== 1'b0 || in_ready_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0 1",
                     out_valid_w[0], in_ready_w[0]);
        end
        checks++;
        if (s_w[0] !== 8'h46) begin
            errors++;
            $display("FAIL bp_release_hold_s: got %h want 46", s_w[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] so;
        logic       co, ov;
        int         lat;
        time        tacc;
        int         seen;
        out_ready[0] = 1'b1;
        a            = 8'hFF;
        b            = 8'h01;
        cin          = 1'b0;
        sub          = 1'b0;
        in_valid[0]  = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_in_ready_during: got %b want 0", in_ready_w[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid_w[0] !== 1'b0 || s_w[0] !== 8'h00) begin
            errors++;
            $display("FAIL midrst_cleared: got out_valid=%b s=%h want 0 00",
                     out_valid_w[0], s_w[0]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_ready_after: got %b want 1", in_ready_w[0]);
        end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (out_valid_w[0]) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrst_no_result: got %0d out_valid cycles want 0", seen);
        end
        do_op(0, 8'h12, 8'h34, 1'b0, 1'b0, so, co, ov, lat, tacc);
        checks++;
        if (lat !== 8 || so !== 8'h46 || co !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL midrst_followup: got lat=%0d s=%h cout=%b ovf=%b want 8 46 0 0",
                     lat, so, co, ov);
        end
    endtask

    task automatic test_back_to_back();
        // 3C+A5+0 = E1; 10-20-1 = EF with borrow; 80+80+1 = 01 with carry and overflow.
        logic [7:0] va [3] = '{8'h3C, 8'h10, 8'h80};
        logic [7:0] vb [3] = '{8'hA5, 8'h20, 8'h80};
        logic       vc [3] = '{1'b0, 1'b1, 1'b1};
        logic       vs [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] es [3] = '{8'hE1, 8'hEF, 8'h01};
        logic       eco[3] = '{1'b0, 1'b1, 1'b1};
        logic       eov[3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] so;
        logic       co, ov;
        int         lat;
        time        tacc, tprev;
        for (int k = 0; k < 4; k++) begin
            out_ready[k] = 1'b1;
            tprev        = 0;
            for (int v = 0; v < 3; v++) begin
                do_op(k, va[v], vb[v], vc[v], vs[v], so, co, ov, lat, tacc);
                checks++;
                if (lat !== n_of(k)) begin
                    errors++;
                    $display("FAIL b2b_latency[d%0d][%0d]: got %0d want %0d",
                             1 << k, v, lat, n_of(k));
                end
                checks++;
                if (so !== es[v] || co !== eco[v] || ov !== eov[v]) begin
                    errors++;
                    $display("FAIL b2b_result[d%0d][%0d]: got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
                             1 << k, v, so, co, ov, es[v], eco[v], eov[v]);
                end
                if (v > 0) begin
                    checks++;
                    if ((tacc - tprev) / 10 != time'(n_of(k) + 2)) begin
                        errors++;
                        $display("FAIL b2b_spacing[d%0d][%0d]: got %0d want %0d",
                                 1 << k, v, (tacc - tprev) / 10, n_of(k) + 2);
                    end
                end
                tprev = tacc;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        sub    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end
        #1;
        test_reset();
        test_add_d1();
        test_sub_d4();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
